// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM bank: register byte map, CTRL bit
// positions and the run/idle state encoding.
package pwm_pkg;

    localparam int CTRL_IDX     = 0;
    localparam int PRESCALE_IDX = 1;
    localparam int TOP_IDX      = 2;
    localparam int DUTY_BASE    = 3;

    localparam int EN_BIT  = 0;
    localparam int INV_BIT = 1;
    localparam int IMM_BIT = 2;

    localparam int STATUS_RUNNING_BIT = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits a one-clk tick every (limit+1) clks while not cleared.
// The limit is live, so lowering it below the running count lets the counter
// roll through 255 before the next tick.
module pwm_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] limit,
    output logic       tick
);

    logic [7:0] pre_cnt;

    assign tick = !clear && (pre_cnt == limit);

    // Count up to the limit, restart on tick, hold at zero while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clear || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator fed by the SPI register bytes.
// TOP and DUTY are shadowed so a period always completes with the values it
// started with, unless IMM asks for immediate updates.
//
// state | meaning
// IDLE  | EN low: counters held at 0, outputs parked at the INV level
// RUN   | EN high: prescaler and period counter advance, outputs compare
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(CHANNELS+3)*8-1:0] cfg,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [7:0]                status
);

    logic         en;
    logic         inv;
    logic         imm;
    logic [7:0]   prescale;
    logic [7:0]   top;
    logic         unused_ctrl;

    assign en       = cfg[CTRL_IDX*8 + EN_BIT];
    assign inv      = cfg[CTRL_IDX*8 + INV_BIT];
    assign imm      = cfg[CTRL_IDX*8 + IMM_BIT];
    assign prescale = cfg[PRESCALE_IDX*8 +: 8];
    assign top      = cfg[TOP_IDX*8 +: 8];

    // CTRL bits 7:3 are reserved.
    assign unused_ctrl = &{1'b0, cfg[CTRL_IDX*8 + 3 +: 5]};

    state_t                state;
    logic                  running;
    logic [7:0]            cnt;
    logic [6:0]            frame;
    logic [7:0]            top_sh;
    logic [7:0]            duty_sh [CHANNELS];
    logic                  go;
    logic                  tick;
    logic                  wrap;
    logic                  load;
    logic [CHANNELS-1:0]   level;

    // Counting only proceeds on clks where the FSM is already in RUN and EN
    // is still high; the clk EN drops is the clk everything is parked.
    assign go   = (state == RUN) && en;
    assign wrap = go && tick && (cnt == top_sh);
    assign load = !en || imm || wrap;

    pwm_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!go),
        .limit (prescale),
        .tick  (tick)
    );

    // Run/idle FSM with the period counter and wrap counter it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
            cnt     <= '0;
            frame   <= '0;
        end else begin
            case (state)
                IDLE: if (en) state <= RUN;
                RUN:  if (!en) state <= IDLE;
                default: state <= IDLE;
            endcase
            running <= en;
            if (!go) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= wrap ? 8'd0 : cnt + 8'd1;
            end
            if (wrap) begin
                frame <= frame + 7'd1;
            end
        end
    end

    // Shadow TOP/DUTY: transparent while idle or in IMM mode, else at wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_sh <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i] <= '0;
            end
        end else if (load) begin
            top_sh <= top;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i] <= cfg[(DUTY_BASE+i)*8 +: 8];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
        assign level[g] = (cnt < duty_sh[g]) ^ inv;
    end

    // Register the compare result; idle parks every pin at the INV level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= go ? level : {CHANNELS{inv}};
        end
    end

    assign status = {frame, running};

endmodule

// File: tb/tb_pwm_bank.sv
module tb_pwm_bank;

    localparam int CH = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [(CH+3)*8-1:0]   cfg;
    logic [CH-1:0]         pwm_out;
    logic [7:0]            status;

    logic [7:0] ctrl, pre, top;
    logic [7:0] duty [CH];

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural reference state
    int          m_pre, m_cnt, m_top, m_frame;
    int          m_duty [CH];
    bit          m_run;
    logic [CH-1:0] m_out;

    int hc [CH];
    int h, found;
    logic p;

    pwm_bank #(.CHANNELS(CH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg),
        .pwm_out (pwm_out),
        .status  (status)
    );

    always #5 clk = ~clk;

    always_comb begin
        cfg = '0;
        cfg[7:0]   = ctrl;
        cfg[15:8]  = pre;
        cfg[23:16] = top;
        for (int i = 0; i < CH; i++) cfg[(3+i)*8 +: 8] = duty[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_cnt = 0; m_top = 0; m_frame = 0; m_run = 0; m_out = '0;
        for (int i = 0; i < CH; i++) m_duty[i] = 0;
    endtask

    // One clk of the reference: output reflects the position held before the
    // edge, then the position advances by one clk of the spec rules.
    task automatic model_step();
        automatic bit en  = ctrl[0];
        automatic bit inv = ctrl[1];
        automatic bit imm = ctrl[2];
        automatic bit active = m_run && en;
        automatic bit wrapped = 0;
        for (int i = 0; i < CH; i++)
            m_out[i] = active ? ((m_cnt < m_duty[i]) ^ inv) : inv;
        if (active) begin
            if (m_pre == int'(pre)) begin
                m_pre = 0;
                if (m_cnt == m_top) begin
                    m_cnt = 0;
                    wrapped = 1;
                    m_frame = (m_frame + 1) % 128;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_pre = (m_pre + 1) % 256;
            end
        end else begin
            m_pre = 0;
            m_cnt = 0;
        end
        if (!en || imm || wrapped) begin
            m_top = int'(top);
            for (int i = 0; i < CH; i++) m_duty[i] = int'(duty[i]);
        end
        m_run = en;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pwm_out", 32'(pwm_out), 32'(m_out));
        check("status", 32'(status), 32'({m_frame[6:0], m_run}));
    endtask

    task automatic run_count(input int n, output int c [CH]);
        for (int i = 0; i < CH; i++) c[i] = 0;
        repeat (n) begin
            cyc();
            for (int i = 0; i < CH; i++) if (pwm_out[i]) c[i]++;
        end
    endtask

    // Advance until channel 0 rises (first clk of a period), bounded.
    task automatic align();
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            p = pwm_out[0];
            cyc();
            if (pwm_out[0] && !p) found = 1;
        end
        check("align_rise", 32'(found), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ctrl = 8'h00; pre = 8'h00; top = 8'h00;
        for (int i = 0; i < CH; i++) duty[i] = 8'h00;
        model_reset();
        #12;
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_status", 32'(status), 32'd0);
        rst_n = 1'b1;
        cyc();

        // basic PWM from idle
        pre = 8'd0; top = 8'd9;
        duty[0] = 8'd3; duty[1] = 8'd0; duty[2] = 8'd10; duty[3] = 8'd5; duty[4] = 8'd255;
        cyc();
        ctrl = 8'h01;
        cyc();
        check("en_edge_out", 32'(pwm_out[0]), 32'd0);
        check("en_edge_frame", 32'(status[7:1]), 32'd0);
        run_count(3, hc);
        check("basic_high", 32'(hc[0]), 32'd3);
        run_count(7, hc);
        check("basic_low", 32'(hc[0]), 32'd0);
        check("basic_frame1", 32'(status[7:1]), 32'd1);
        run_count(10, hc);
        check("basic_period", 32'(hc[0]), 32'd3);
        check("duty0_const", 32'(hc[1]), 32'd0);
        check("duty_gt_top", 32'(hc[2]), 32'd10);
        check("duty3", 32'(hc[3]), 32'd5);
        check("basic_frame2", 32'(status[7:1]), 32'd2);

        // shadowed duty change mid-period
        align();
        run_count(4, hc);
        h = 1 + hc[0];
        duty[0] = 8'd7;
        run_count(5, hc);
        h = h + hc[0];
        check("shadow_old_period", 32'(h), 32'd3);
        run_count(10, hc);
        check("shadow_new_period", 32'(hc[0]), 32'd7);

        // immediate duty change
        ctrl = 8'h05;
        align();
        duty[0] = 8'd5;
        run_count(9, hc);
        check("imm_period", 32'(hc[0] + 1), 32'd5);

        // boundaries, plain and inverted
        ctrl = 8'h01; duty[0] = 8'd0; duty[1] = 8'd10;
        run_count(25, hc);
        run_count(20, hc);
        check("bound_zero", 32'(hc[0]), 32'd0);
        check("bound_full", 32'(hc[1]), 32'd20);
        ctrl = 8'h03;
        run_count(2, hc);
        run_count(20, hc);
        check("inv_zero", 32'(hc[0]), 32'd20);
        check("inv_full", 32'(hc[1]), 32'd0);
        ctrl = 8'h02;
        cyc(); cyc();
        check("idle_inv_out", 32'(pwm_out), 32'h1F);
        check("idle_running", 32'(status[0]), 32'd0);

        // prescaled run from idle
        ctrl = 8'h00; pre = 8'd3; top = 8'd4; duty[0] = 8'd2;
        cyc();
        ctrl = 8'h01;
        cyc();
        check("pre_en_edge", 32'(pwm_out[0]), 32'd0);
        run_count(8, hc);
        check("pre_high", 32'(hc[0]), 32'd8);
        run_count(12, hc);
        check("pre_low", 32'(hc[0]), 32'd0);
        run_count(20, hc);
        check("pre_period", 32'(hc[0]), 32'd8);

        // asynchronous reset mid-period
        ctrl = 8'h00; pre = 8'd0; top = 8'd200; duty[0] = 8'd150;
        cyc();
        ctrl = 8'h01;
        repeat (101) cyc();
        check("mid_run_high", 32'(pwm_out[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_status", 32'(status), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;

        // frame wrap over 130 periods, then disable mid-period
        ctrl = 8'h00; top = 8'd1; duty[0] = 8'd1;
        cyc();
        ctrl = 8'h01;
        cyc();
        check("frame_start", 32'(status[7:1]), 32'd0);
        repeat (260) cyc();
        check("frame_wrap", 32'(status[7:1]), 32'd2);
        check("frame_running", 32'(status[0]), 32'd1);
        cyc();
        ctrl = 8'h02;
        cyc();
        check("dis_running", 32'(status[0]), 32'd0);
        check("dis_out", 32'(pwm_out), 32'h1F);
        check("dis_frame", 32'(status[7:1]), 32'd2);
        cyc();
        check("dis_frame_hold", 32'(status[7:1]), 32'd2);

        // randomized configuration traffic against the reference
        repeat (700) begin
            if ($urandom_range(0, 7) == 0) begin
                ctrl = 8'($urandom_range(0, 255));
                ctrl[0] = ($urandom_range(0, 9) != 0);
                pre = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 3));
                top = 8'($urandom_range(0, 15));
                for (int i = 0; i < CH; i++) duty[i] = 8'($urandom_range(0, 18));
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
